alu_uart_interface: RTL and testbench

//   Command sequencer that drives the ALU's operand/opcode side and returns its result.

---
 rtl/alu_uart_interface.sv | 160 ++++++++++++++++
 tb/tb_alu_uart_interface.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_interface.sv
// -----------------------------------------------------------------------------
// alu_uart_interface
//   Command sequencer between the UART byte handshakes and a combinational ALU.
//   It collects three rx bytes in order: operand A, operand B, then the opcode.
//   The operands and opcode are held stable on the ALU inputs.
//   After one settle cycle the ALU result is registered and sent as one tx byte.
//
// Optional feature macro: ALU_OPCODE_CHECK_EN
//   When defined, an opcode outside the supported set is rejected. A rejected
//   opcode pulses op_err, and the FSM waits in ST_OP for a resend.
//   When undefined, any opcode is accepted and op_err is tied to 0.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   rx_data    in   received byte
//   rx_valid   in   one-cycle strobe, rx_data valid
//   alu_result in   combinational ALU output
//   tx_busy    in   transmitter busy, no start issued while high
//   tx_done    in   one-cycle strobe, byte fully transmitted
//   dato_a     out  operand A to the ALU
//   dato_b     out  operand B to the ALU
//   opcode     out  opcode to the ALU
//   tx_data    out  result byte to the transmitter
//   tx_start   out  one-cycle pulse, start transmitting tx_data
//   busy       out  high while executing, sending or waiting for tx_done
//   rx_drop    out  one-cycle pulse, an rx byte was discarded
//   op_err     out  one-cycle pulse, opcode rejected
// -----------------------------------------------------------------------------
module alu_uart_interface #(
  parameter int unsigned NB_DATA   = 8,
  parameter int unsigned NB_OPCODE = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NB_DATA-1:0]   rx_data,
  input  logic                 rx_valid,
  input  logic [NB_DATA-1:0]   alu_result,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [NB_DATA-1:0]   dato_a,
  output logic [NB_DATA-1:0]   dato_b,
  output logic [NB_OPCODE-1:0] opcode,
  output logic [NB_DATA-1:0]   tx_data,
  output logic                 tx_start,
  output logic                 busy,
  output logic                 rx_drop,
  output logic                 op_err
);

  typedef enum logic [2:0] {
    ST_A    = 3'd0,
    ST_B    = 3'd1,
    ST_OP   = 3'd2,
    ST_EXEC = 3'd3,
    ST_SEND = 3'd4,
    ST_WAIT = 3'd5
  } state_t;

  state_t                 state;
  logic [NB_OPCODE-1:0]   rx_op_c;
  logic                   opcode_ok_c;

  // Opcode field of the incoming byte; the upper bits are ignored
  assign rx_op_c = rx_data[NB_OPCODE-1:0];

`ifdef ALU_OPCODE_CHECK_EN
  // Opcodes the attached ALU implements
  always_comb begin
    opcode_ok_c = (rx_op_c == NB_OPCODE'(8'h20)) ||
                  (rx_op_c == NB_OPCODE'(8'h22)) ||
                  (rx_op_c == NB_OPCODE'(8'h24)) ||
                  (rx_op_c == NB_OPCODE'(8'h25)) ||
                  (rx_op_c == NB_OPCODE'(8'h26)) ||
                  (rx_op_c == NB_OPCODE'(8'h03)) ||
                  (rx_op_c == NB_OPCODE'(8'h02)) ||
                  (rx_op_c == NB_OPCODE'(8'h27));
  end
`else
  assign opcode_ok_c = 1'b1;
  assign op_err      = 1'b0;
`endif

  // Command sequencer; every output is registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_A;
      dato_a   <= '0;
      dato_b   <= '0;
      opcode   <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      rx_drop  <= 1'b0;
`ifdef ALU_OPCODE_CHECK_EN
      op_err   <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      rx_drop  <= 1'b0;
`ifdef ALU_OPCODE_CHECK_EN
      op_err   <= 1'b0;
`endif
      case (state)
        ST_A: begin
          if (rx_valid) begin
            dato_a <= rx_data;
            state  <= ST_B;
          end
        end
        ST_B: begin
          if (rx_valid) begin
            dato_b <= rx_data;
            state  <= ST_OP;
          end
        end
        ST_OP: begin
          if (rx_valid) begin
            if (opcode_ok_c) begin
              opcode <= rx_op_c;
              busy   <= 1'b1;
              state  <= ST_EXEC;
            end
`ifdef ALU_OPCODE_CHECK_EN
            else begin
              op_err <= 1'b1;
            end
`endif
          end
        end
        // One full cycle of ALU settle time on the registered inputs
        ST_EXEC: begin
          rx_drop <= rx_valid;
          tx_data <= alu_result;
          state   <= ST_SEND;
        end
        ST_SEND: begin
          rx_drop <= rx_valid;
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= ST_WAIT;
          end
        end
        // A byte arriving together with tx_done is still dropped
        ST_WAIT: begin
          rx_drop <= rx_valid;
          if (tx_done) begin
            busy  <= 1'b0;
            state <= ST_A;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_interface.sv
// -----------------------------------------------------------------------------
// tb_alu_uart_interface
//   Directed self-checking bench for alu_uart_interface, with a behavioural ALU
//   model attached. Each scenario task drives its own stimulus and checks the
//   hand-computed values inline.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_uart_interface;

  localparam int unsigned NB_DATA   = 8;
  localparam int unsigned NB_OPCODE = 6;

  logic                 clk;
  logic                 reset;
  logic [NB_DATA-1:0]   rx_data;
  logic                 rx_valid;
  logic [NB_DATA-1:0]   alu_result;
  logic                 tx_busy;
  logic                 tx_done;
  logic [NB_DATA-1:0]   dato_a;
  logic [NB_DATA-1:0]   dato_b;
  logic [NB_OPCODE-1:0] opcode;
  logic [NB_DATA-1:0]   tx_data;
  logic                 tx_start;
  logic                 busy;
  logic                 rx_drop;
  logic                 op_err;

  int checks;
  int errors;

  alu_uart_interface #(.NB_DATA(NB_DATA), .NB_OPCODE(NB_OPCODE)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .alu_result(alu_result), .tx_busy(tx_busy), .tx_done(tx_done),
    .dato_a(dato_a), .dato_b(dato_b), .opcode(opcode), .tx_data(tx_data),
    .tx_start(tx_start), .busy(busy), .rx_drop(rx_drop), .op_err(op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU for the eight supported opcodes
  always_comb begin
    case (opcode)
      6'h20:   alu_result = dato_a + dato_b;
      6'h22:   alu_result = dato_a - dato_b;
      6'h24:   alu_result = dato_a & dato_b;
      6'h25:   alu_result = dato_a | dato_b;
      6'h26:   alu_result = dato_a ^ dato_b;
      6'h03:   alu_result = NB_DATA'($signed(dato_a) >>> dato_b);
      6'h02:   alu_result = dato_a >> dato_b;
      6'h27:   alu_result = ~(dato_a | dato_b);
      default: alu_result = '0;
    endcase
  end

  // Present one byte for one cycle; returns at the negedge after it was sampled
  task automatic send_byte(input logic [NB_DATA-1:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // One-cycle tx_done strobe
  task automatic pulse_tx_done();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({dato_a, dato_b, opcode, tx_data, tx_start, busy, rx_drop, op_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%h b=%h op=%h tx=%h st=%b busy=%b drop=%b err=%b, need all 0",
               dato_a, dato_b, opcode, tx_data, tx_start, busy, rx_drop, op_err);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
  endtask

  task automatic test_normal();
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    checks++;
    if (dato_a !== 8'h05 || dato_b !== 8'h03 || opcode !== 6'h20) begin
      errors++;
      $display("FAIL normal_operands: got a=%h b=%h op=%h need 05 03 20", dato_a, dato_b, opcode);
    end
    checks++;
    if (busy !== 1'b1 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL normal_exec: got busy=%b st=%b need 1 0", busy, tx_start);
    end
    @(negedge clk);
    checks++;
    if (tx_data !== 8'h08 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL normal_result: got tx=%h st=%b need 08 0", tx_data, tx_start);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL normal_start: got %b need 1", tx_start); end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL normal_start_pulse: got st=%b busy=%b need 0 1", tx_start, busy);
    end
    pulse_tx_done();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL normal_done: got busy=%b need 0", busy); end
  endtask

  task automatic test_tx_busy();
    tx_busy = 1'b1;
    send_byte(8'h0F);
    send_byte(8'h01);
    send_byte(8'h22);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (tx_start !== 1'b0) begin
        errors++;
        $display("FAIL busy_holdoff: cycle %0d got st=%b need 0", i, tx_start);
      end
    end
    tx_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h0E) begin
      errors++;
      $display("FAIL busy_release: got st=%b tx=%h need 1 0e", tx_start, tx_data);
    end
    pulse_tx_done();
  endtask

  task automatic test_overrun();
    send_byte(8'h0C);
    send_byte(8'h0A);
    send_byte(8'h24);
    repeat (3) @(negedge clk);
    checks++;
    if (tx_data !== 8'h08) begin errors++; $display("FAIL overrun_result: got %h need 08", tx_data); end
    send_byte(8'hAA);
    checks++;
    if (rx_drop !== 1'b1 || dato_a !== 8'h0C) begin
      errors++;
      $display("FAIL overrun_drop: got drop=%b a=%h need 1 0c", rx_drop, dato_a);
    end
    @(negedge clk);
    checks++;
    if (rx_drop !== 1'b0) begin errors++; $display("FAIL overrun_drop_pulse: got %b need 0", rx_drop); end
    pulse_tx_done();
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h20);
    checks++;
    if (dato_a !== 8'h03 || dato_b !== 8'h04 || opcode !== 6'h20) begin
      errors++;
      $display("FAIL overrun_next_cmd: got a=%h b=%h op=%h need 03 04 20", dato_a, dato_b, opcode);
    end
    @(negedge clk);
    checks++;
    if (tx_data !== 8'h07) begin errors++; $display("FAIL overrun_next_result: got %h need 07", tx_data); end
    @(negedge clk);
    pulse_tx_done();
  endtask

  task automatic test_reset_mid();
    send_byte(8'h11);
    send_byte(8'h22);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({dato_a, dato_b, opcode, tx_data, tx_start, busy, rx_drop, op_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got a=%h b=%h op=%h tx=%h st=%b busy=%b, need all 0",
               dato_a, dato_b, opcode, tx_data, tx_start, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h20);
    @(negedge clk);
    checks++;
    if (tx_data !== 8'h02) begin errors++; $display("FAIL reset_mid_result: got %h need 02", tx_data); end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL reset_mid_start: got %b need 1", tx_start); end
    pulse_tx_done();
  endtask

  task automatic test_opcode_check();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h3F);
`ifdef ALU_OPCODE_CHECK_EN
    checks++;
    if (op_err !== 1'b1 || opcode !== 6'h20 || busy !== 1'b0) begin
      errors++;
      $display("FAIL opchk_reject: got err=%b op=%h busy=%b need 1 20 0", op_err, opcode, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (op_err !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL opchk_idle: got err=%b st=%b need 0 0", op_err, tx_start);
    end
    send_byte(8'h25);
    checks++;
    if (opcode !== 6'h25 || dato_a !== 8'h01 || dato_b !== 8'h02) begin
      errors++;
      $display("FAIL opchk_resend: got op=%h a=%h b=%h need 25 01 02", opcode, dato_a, dato_b);
    end
    @(negedge clk);
    checks++;
    if (tx_data !== 8'h03) begin errors++; $display("FAIL opchk_result: got %h need 03", tx_data); end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL opchk_start: got %b need 1", tx_start); end
`else
    checks++;
    if (op_err !== 1'b0 || opcode !== 6'h3F || busy !== 1'b1) begin
      errors++;
      $display("FAIL opchk_accept: got err=%b op=%h busy=%b need 0 3f 1", op_err, opcode, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL opchk_start: got %b need 1", tx_start); end
`endif
    pulse_tx_done();
  endtask

  task automatic test_back_to_back();
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h20);
    repeat (3) @(negedge clk);
    checks++;
    if (tx_data !== 8'h05 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got tx=%h busy=%b need 05 1", tx_data, busy);
    end
    // tx_done and a new byte in the same cycle: byte is dropped
    @(negedge clk);
    tx_done  = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h07;
    @(negedge clk);
    tx_done  = 1'b0;
    rx_valid = 1'b0;
    checks++;
    if (rx_drop !== 1'b1 || busy !== 1'b0 || dato_a !== 8'h02) begin
      errors++;
      $display("FAIL b2b_drop: got drop=%b busy=%b a=%h need 1 0 02", rx_drop, busy, dato_a);
    end
    send_byte(8'h04);
    send_byte(8'h09);
    send_byte(8'h26);
    @(negedge clk);
    checks++;
    if (tx_data !== 8'h0D) begin errors++; $display("FAIL b2b_result: got %h need 0d", tx_data); end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL b2b_start: got %b need 1", tx_start); end
    pulse_tx_done();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_busy  = 1'b0;
    tx_done  = 1'b0;
    test_reset();
    test_normal();
    test_tx_busy();
    test_overrun();
    test_reset_mid();
    test_opcode_check();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
